intersection_scheduler: RTL



---
 rtl/intersection_scheduler_if.sv | 21 ++
 rtl/intersection_scheduler.sv | 115 +++++++++++
 2 files changed

// File: rtl/intersection_scheduler_if.sv
// Request inputs and lamp/status outputs of the intersection scheduler.
// Lamp vectors are [0:2] with index 0 = R, 1 = G, 2 = Y.
interface intersection_scheduler_if;
  logic       side_req;
  logic       ped_req;
  logic [0:2] main_light;
  logic [0:2] side_light;
  logic       walk;
  logic [2:0] phase;
  logic       ped_pending;

  modport master (
    output side_req, ped_req,
    input  main_light, side_light, walk, phase, ped_pending
  );

  modport slave (
    input  side_req, ped_req,
    output main_light, side_light, walk, phase, ped_pending
  );
endinterface

// File: rtl/intersection_scheduler.sv
// Demand-driven two-road intersection controller with a pedestrian walk phase.
// Main road rests in green; every phase is timed from one shared saturating counter.
module intersection_scheduler #(
  parameter int GREEN_MIN = 8,
  parameter int GREEN_MAX = 20,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2,
  parameter int WALK_T    = 6,
  parameter int CW        = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  intersection_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED_1   = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    ALL_RED_2   = 3'd5,
    WALK        = 3'd6
  } state_t;

  // Exit points: a phase of duration D leaves when the timer reads D-1.
  localparam logic [CW-1:0] GMIN_LAST  = CW'(GREEN_MIN - 1);
  localparam logic [CW-1:0] GMAX_LAST  = CW'(GREEN_MAX - 1);
  localparam logic [CW-1:0] YEL_LAST   = CW'(YELLOW_T - 1);
  localparam logic [CW-1:0] ARED_LAST  = CW'(ALLRED_T - 1);
  localparam logic [CW-1:0] WALK_LAST  = CW'(WALK_T - 1);

  state_t        state_reg, state_next;
  logic [CW-1:0] timer_reg;
  logic          ped_reg, ped_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= MAIN_GREEN;
      timer_reg <= '0;
      ped_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      ped_reg   <= ped_next;
      if (state_next != state_reg) begin
        timer_reg <= '0;
      end else if (timer_reg != '1) begin
        timer_reg <= timer_reg + 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      MAIN_GREEN: begin
        if (timer_reg >= GMIN_LAST && (bus.side_req || ped_reg)) begin
          state_next = MAIN_YELLOW;
        end
      end
      MAIN_YELLOW: begin
        if (timer_reg == YEL_LAST) state_next = ALL_RED_1;
      end
      ALL_RED_1: begin
        // Pedestrians win over the side road; vanished demand returns to main.
        if (timer_reg == ARED_LAST) begin
          if (ped_reg)           state_next = WALK;
          else if (bus.side_req) state_next = SIDE_GREEN;
          else                   state_next = MAIN_GREEN;
        end
      end
      SIDE_GREEN: begin
        if ((timer_reg >= GMIN_LAST && !bus.side_req) || timer_reg == GMAX_LAST) begin
          state_next = SIDE_YELLOW;
        end
      end
      SIDE_YELLOW: begin
        if (timer_reg == YEL_LAST) state_next = ALL_RED_2;
      end
      WALK: begin
        if (timer_reg == WALK_LAST) state_next = ALL_RED_2;
      end
      ALL_RED_2: begin
        if (timer_reg == ARED_LAST) state_next = MAIN_GREEN;
      end
      default: state_next = MAIN_GREEN;
    endcase
  end

  // The latch is cleared on entry to WALK and stays deaf for the whole phase.
  always_comb begin
    ped_next = ped_reg | bus.ped_req;
    if (state_next == WALK || state_reg == WALK) begin
      ped_next = 1'b0;
    end
  end

  always_comb begin
    bus.main_light = 3'b100;
    bus.side_light = 3'b100;
    bus.walk       = 1'b0;
    case (state_reg)
      MAIN_GREEN:  bus.main_light = 3'b010;
      MAIN_YELLOW: bus.main_light = 3'b001;
      SIDE_GREEN:  bus.side_light = 3'b010;
      SIDE_YELLOW: bus.side_light = 3'b001;
      WALK:        bus.walk       = 1'b1;
      default: ;
    endcase
  end

  assign bus.phase       = state_reg;
  assign bus.ped_pending = ped_reg;

endmodule
